// File: rtl/impact_access_sequencer_pkg.sv
// Shared types and constants for the IMPACT SRAM access sequencer.
// FSM state encoding, op codes and default pin-timing values.
package impact_access_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPre  = 3'd1,
    StRd   = 3'd2,
    StWr   = 3'd3,
    StHold = 3'd4,
    StResp = 3'd5
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int unsigned DEF_PRE_CYCLES = 2;
  localparam int unsigned DEF_ACC_CYCLES = 2;
  localparam int unsigned DEF_MUX_LAT    = 1;
  localparam int unsigned DEF_WORD_W     = 10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/impact_phase_timer.sv
// Reusable phase down-counter: loaded on phase entry, done while the count sits at 1.
// Saturates at 1 so a phase that is not reloaded never wraps.
module impact_phase_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             done
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q > Width'(1)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == Width'(1));

endmodule

// File: rtl/impact_access_sequencer.sv
// Host-request to SRAM-head pin sequencer: precharge, then read or write strobe, then a
// valid/ready response. Every output is registered from the next state.
module impact_access_sequencer
  import impact_access_sequencer_pkg::*;
#(
  parameter int unsigned PRE_CYCLES = DEF_PRE_CYCLES,
  parameter int unsigned ACC_CYCLES = DEF_ACC_CYCLES,
  parameter int unsigned MUX_LAT    = DEF_MUX_LAT,
  parameter int unsigned WORD_W     = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_bank,
  input  logic [WORD_W-1:0] req_word,
  input  logic [1:0]        req_byte,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [7:0]        rsp_rdata,
  input  logic [7:0]        sram_data_out,
  output logic [7:0]        sram_data_in,
  output logic [WORD_W-1:0] sram_word_sel,
  output logic [1:0]        sram_bank_sel,
  output logic [1:0]        sram_byte_sel,
  output logic              sram_pre,
  output logic              sram_we,
  output logic              sram_re,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(max_u(PRE_CYCLES, ACC_CYCLES + MUX_LAT)) + 1;

  state_e state_q, state_d;
  logic   op_q;
  logic   accept;

  logic            timer_load;
  logic [CntW-1:0] timer_val;
  logic            timer_done;

  logic pre_d, we_d, re_d, rsp_valid_d, ready_d, busy_d;

  assign accept = req_valid && req_ready;

  impact_phase_timer #(
    .Width(CntW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_val),
    .done    (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // The timer is loaded on the same edge the state enters each timed phase.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StPre;
          timer_load = 1'b1;
          timer_val  = CntW'(PRE_CYCLES);
        end
      end
      StPre: begin
        if (timer_done) begin
          timer_load = 1'b1;
          if (op_q == OP_WRITE) begin
            state_d   = StWr;
            timer_val = CntW'(ACC_CYCLES);
          end else begin
            state_d   = StRd;
            timer_val = CntW'(ACC_CYCLES + MUX_LAT);
          end
        end
      end
      StRd: begin
        if (timer_done) state_d = StResp;
      end
      StWr: begin
        if (timer_done) begin
          state_d    = StHold;
          timer_load = 1'b1;
          timer_val  = CntW'(1);
        end
      end
      StHold: begin
        if (timer_done) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pre_d       = (state_d == StPre);
    we_d        = (state_d == StWr);
    re_d        = (state_d == StRd);
    rsp_valid_d = (state_d == StResp);
    ready_d     = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      sram_pre      <= 1'b0;
      sram_we       <= 1'b0;
      sram_re       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      op_q          <= OP_READ;
      sram_data_in  <= '0;
      sram_word_sel <= '0;
      sram_bank_sel <= '0;
      sram_byte_sel <= '0;
    end else begin
      req_ready <= ready_d;
      busy      <= busy_d;
      sram_pre  <= pre_d;
      sram_we   <= we_d;
      sram_re   <= re_d;
      rsp_valid <= rsp_valid_d;
      if (accept) begin
        op_q          <= req_write;
        sram_data_in  <= req_wdata;
        sram_word_sel <= req_word;
        sram_bank_sel <= req_bank;
        sram_byte_sel <= req_byte;
      end
      // Read data is captured on the edge that ends the last RD cycle.
      if (state_q == StRd && state_d == StResp) begin
        rsp_rdata <= sram_data_out;
        rsp_write <= OP_READ;
      end
      if (state_q == StHold && state_d == StResp) begin
        rsp_rdata <= '0;
        rsp_write <= OP_WRITE;
      end
    end
  end

endmodule

// File: tb/tb_impact_access_sequencer.sv
// Self-checking bench: table vectors, hand-written corner sequences and random transactions
// against a byte-memory reference model plus a pin-level SRAM emulator.
module tb_impact_access_sequencer;

  localparam int unsigned PRE    = 2;
  localparam int unsigned ACC    = 2;
  localparam int unsigned MUX    = 1;
  localparam int unsigned WORD_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_bank = '0;
  logic [WORD_W-1:0] req_word = '0;
  logic [1:0]        req_byte = '0;
  logic [7:0]        req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_write;
  logic [7:0]        rsp_rdata;
  logic [7:0]        sram_data_out;
  logic [7:0]        sram_data_in;
  logic [WORD_W-1:0] sram_word_sel;
  logic [1:0]        sram_bank_sel;
  logic [1:0]        sram_byte_sel;
  logic              sram_pre;
  logic              sram_we;
  logic              sram_re;
  logic              busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] sram_mem  [0:16383];
  logic [7:0] model_mem [0:16383];

  impact_access_sequencer #(
    .PRE_CYCLES(PRE),
    .ACC_CYCLES(ACC),
    .MUX_LAT   (MUX),
    .WORD_W    (WORD_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_bank     (req_bank),
    .req_word     (req_word),
    .req_byte     (req_byte),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .sram_data_out(sram_data_out),
    .sram_data_in (sram_data_in),
    .sram_word_sel(sram_word_sel),
    .sram_bank_sel(sram_bank_sel),
    .sram_byte_sel(sram_byte_sel),
    .sram_pre     (sram_pre),
    .sram_we      (sram_we),
    .sram_re      (sram_re),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Pin-level head emulator.
  assign sram_data_out = sram_mem[{sram_bank_sel, sram_word_sel, sram_byte_sel}];
  always @(posedge clk) begin
    if (sram_we) sram_mem[{sram_bank_sel, sram_word_sel, sram_byte_sel}] <= sram_data_in;
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0({sram_pre, sram_we, sram_re})) begin
        failures++;
        $display("FAIL strobe_onehot actual=%b required=at-most-one-high",
                 {sram_pre, sram_we, sram_re});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int addr_of(input logic [1:0] bk, input logic [9:0] wd, input logic [1:0] by);
    return int'({bk, wd, by});
  endfunction

  task automatic run_txn(input logic wr, input logic [1:0] bk, input logic [9:0] wd,
                         input logic [1:0] by, input logic [7:0] dat, input logic exp_wr,
                         input logic [7:0] exp_rd, input int stall, input bit stall_req,
                         input bit ready_early);
    int cyc, wait_n, pre_first, pre_n, acc_first, acc_n, wrong_n, rsp_cyc, exp_rsp;
    bit sel_ok, stall_ok, idle_ok;
    wait_n = 0;
    @(negedge clk);
    while (!req_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_bank = bk; req_word = wd; req_byte = by;
    req_wdata = dat; rsp_ready = ready_early;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_word = WORD_W'($urandom); req_bank = 2'($urandom); req_wdata = 8'($urandom);
    cyc = 0; pre_first = 0; pre_n = 0; acc_first = 0; acc_n = 0; wrong_n = 0; rsp_cyc = 0;
    sel_ok = 1'b1;
    while (rsp_cyc == 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (sram_pre) begin
        if (pre_first == 0) pre_first = cyc;
        pre_n++;
      end
      if ((wr && sram_we) || (!wr && sram_re)) begin
        if (acc_first == 0) acc_first = cyc;
        acc_n++;
      end
      if ((wr && sram_re) || (!wr && sram_we)) wrong_n++;
      if (sram_bank_sel != bk || sram_word_sel != wd || sram_byte_sel != by ||
          sram_data_in != dat) sel_ok = 1'b0;
      if (rsp_valid) rsp_cyc = cyc;
    end
    exp_rsp = wr ? int'(PRE + ACC + 2) : int'(PRE + ACC + MUX + 1);
    check("pre_first_cycle", pre_first, 1);
    check("pre_cycle_count", pre_n, PRE);
    check("strobe_first_cycle", acc_first, PRE + 1);
    check("strobe_cycle_count", acc_n, wr ? ACC : ACC + MUX);
    check("wrong_strobe_cycles", wrong_n, 0);
    check("rsp_valid_cycle", rsp_cyc, exp_rsp);
    check("sel_data_held", sel_ok, 1);
    check("rsp_write", rsp_write, exp_wr);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("busy_in_resp", busy, 1);
    if (!ready_early) begin
      stall_ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
        if (stall_req) begin
          req_valid = 1'b1; req_write = 1'($urandom); req_word = WORD_W'($urandom);
          req_bank = 2'($urandom); req_byte = 2'($urandom);
        end
        @(negedge clk);
        if (!rsp_valid || rsp_rdata != exp_rd || rsp_write != exp_wr || req_ready ||
            sram_pre || sram_we || sram_re) stall_ok = 1'b0;
      end
      check("resp_stable_during_stall", stall_ok, 1);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_after_handshake", rsp_valid, 0);
    check("req_ready_after_handshake", req_ready, 1);
    if (stall_req) begin
      idle_ok = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (busy || sram_pre || sram_word_sel != wd || sram_bank_sel != bk) idle_ok = 1'b0;
      end
      check("stalled_req_not_queued", idle_ok, 1);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [1:0] bk;
    logic [9:0] wd;
    logic [1:0] by;
    logic [7:0] dat;
    int         stall;
    bit         stall_req;
    bit         early;
    logic       exp_wr;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic       r_wr;
    logic [1:0] r_bk, r_by;
    logic [9:0] r_wd;
    logic [7:0] r_dat, r_exp;
    bit         seen;

    for (int i = 0; i < 16384; i++) begin
      sram_mem[i] = 8'h00;
      model_mem[i] = 8'h00;
    end
    sram_mem[addr_of(2'd0, 10'h000, 2'd0)]  = 8'h5A;
    model_mem[addr_of(2'd0, 10'h000, 2'd0)] = 8'h5A;

    vecs[0] = '{1'b1, 2'd2, 10'h3FF, 2'd3, 8'hA5, 0, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 2'd0, 10'h000, 2'd0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h5A};
    vecs[2] = '{1'b0, 2'd2, 10'h3FF, 2'd3, 8'h11, 20, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[3] = '{1'b1, 2'd1, 10'h155, 2'd1, 8'h3C, 0, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[4] = '{1'b0, 2'd1, 10'h155, 2'd1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[5] = '{1'b1, 2'd3, 10'h000, 2'd2, 8'hFF, 2, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 2'd3, 10'h000, 2'd2, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'hFF};
    vecs[7] = '{1'b0, 2'd1, 10'h155, 2'd2, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00};

    // Reset values and quiet idle.
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_outputs_zero",
          {rsp_valid, rsp_write, rsp_rdata, sram_data_in, sram_word_sel, sram_bank_sel,
           sram_byte_sel, sram_pre, sram_we, sram_re, busy}, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", {req_ready, rsp_valid, sram_pre, sram_we, sram_re, busy}, 6'b100000);
    end

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].wr, vecs[i].bk, vecs[i].wd, vecs[i].by, vecs[i].dat, vecs[i].exp_wr,
              vecs[i].exp_rd, vecs[i].stall, vecs[i].stall_req, vecs[i].early);
      if (vecs[i].wr) model_mem[addr_of(vecs[i].bk, vecs[i].wd, vecs[i].by)] = vecs[i].dat;
    end

    // Reset during RD cycle 4 aborts the read.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_bank = 2'd1; req_word = 10'h2AA; req_byte = 2'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("re_high_cycle4", sram_re, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("strobes_after_rst", {sram_pre, sram_we, sram_re}, 0);
    check("rsp_valid_after_rst", rsp_valid, 0);
    check("req_ready_after_rst", req_ready, 1);
    check("busy_after_rst", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || sram_pre || sram_we || sram_re) seen = 1'b1;
    end
    check("no_activity_after_rst", seen, 0);
    run_txn(1'b1, 2'd1, 10'h2AA, 2'd0, 8'h77, 1'b1, 8'h00, 0, 1'b0, 1'b0);
    model_mem[addr_of(2'd1, 10'h2AA, 2'd0)] = 8'h77;
    run_txn(1'b0, 2'd1, 10'h2AA, 2'd0, 8'h00, 1'b0, 8'h77, 0, 1'b0, 1'b1);

    // Random traffic over a small address pool for frequent read-after-write hits.
    for (int n = 0; n < 40; n++) begin
      r_wr  = 1'($urandom);
      r_bk  = 2'($urandom);
      r_wd  = ($urandom_range(0, 1) == 1) ? 10'h3FF : 10'h000;
      r_by  = 2'($urandom);
      r_dat = 8'($urandom);
      r_exp = r_wr ? 8'h00 : model_mem[addr_of(r_bk, r_wd, r_by)];
      run_txn(r_wr, r_bk, r_wd, r_by, r_dat, r_wr, r_exp, int'($urandom_range(0, 3)), 1'b0,
              ($urandom_range(0, 2) == 0));
      if (r_wr) model_mem[addr_of(r_bk, r_wd, r_by)] = r_dat;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
